// File: rtl/alu_exec_stage_pkg.sv
// Shared definitions for the ALU execute stage: widths, ALU opcode encodings
// and the output-buffer entry layout.
package alu_exec_stage_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 5;
  localparam int TAG_W  = 5;

  typedef enum logic [OP_W-1:0] {
    ADD_  = 5'd0,
    SUB_  = 5'd1,
    AND_  = 5'd2,
    OR_   = 5'd3,
    XOR_  = 5'd4,
    SLL_  = 5'd5,
    SRL_  = 5'd6,
    SRA_  = 5'd7,
    SLT_  = 5'd8,
    SLTU_ = 5'd9,
    BEQ_  = 5'd10,
    BNE_  = 5'd11,
    BLT_  = 5'd12,
    BGE_  = 5'd13,
    BLTU_ = 5'd14,
    BGEU_ = 5'd15
  } alu_ops_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              flag;
    logic [TAG_W-1:0]  tag;
  } alu_entry_t;

endpackage

// File: rtl/alu_exec_stage_alu.sv
// Combinational ALU: arithmetic/logic results plus a branch-condition flag.
// Branch ops leave Result at zero; undefined opcodes produce zero and no flag.
module alu_exec_stage_alu #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              flag_o
);
  import alu_exec_stage_pkg::*;

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;
  logic            lt_s;
  logic            lt_u;
  logic            eq;

  assign shamt = b_i[SH_W-1:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;
  assign eq    = a_i == b_i;

  always_comb begin
    result_o = '0;
    flag_o   = 1'b0;
    case (op_i)
      ADD_:  result_o = a_i + b_i;
      SUB_:  result_o = a_i - b_i;
      AND_:  result_o = a_i & b_i;
      OR_:   result_o = a_i | b_i;
      XOR_:  result_o = a_i ^ b_i;
      SLL_:  result_o = a_i << shamt;
      SRL_:  result_o = a_i >> shamt;
      SRA_:  result_o = $unsigned($signed(a_i) >>> shamt);
      SLT_:  result_o = {{(DATA_W-1){1'b0}}, lt_s};
      SLTU_: result_o = {{(DATA_W-1){1'b0}}, lt_u};
      BEQ_:  flag_o   = eq;
      BNE_:  flag_o   = ~eq;
      BLT_:  flag_o   = lt_s;
      BGE_:  flag_o   = ~lt_s;
      BLTU_: flag_o   = lt_u;
      BGEU_: flag_o   = ~lt_u;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute stage: ALU evaluated in the accept cycle, results held in
// a small in-order buffer until writeback/branch logic pops them.
module alu_exec_stage #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int OP_W   = 5,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [OP_W-1:0]   in_op,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_flag,
  output logic [TAG_W-1:0]  out_tag,
  output logic [31:0]       op_count
);
  import alu_exec_stage_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] alu_result;
  logic              alu_flag;

  alu_exec_stage_alu #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .a_i      (in_a),
    .b_i      (in_b),
    .op_i     (in_op),
    .result_o (alu_result),
    .flag_o   (alu_flag)
  );

  alu_entry_t        mem_q [DEPTH];
  alu_entry_t        wr_entry;
  alu_entry_t        head;
  logic [DEPTH-1:0]  wr_en;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic              in_ready_q;
  logic [31:0]       op_count_q, op_count_d;
  logic              accept;
  logic              pop;

  assign accept   = in_valid & in_ready_q & ~flush;
  assign pop      = out_valid & out_ready & ~flush;
  assign wr_entry = '{result: alu_result, flag: alu_flag, tag: in_tag};

  // Pointers and occupancy snap back to zero on flush; buffered data is left stale.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    op_count_d = op_count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (accept) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        op_count_d = op_count_q + 32'd1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({accept, pop})
        2'b10:   occ_d = occ_q + CNT_W'(1);
        2'b01:   occ_d = occ_q - CNT_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      in_ready_q <= 1'b0;
      op_count_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      in_ready_q <= (occ_d < DEPTH_C);
      op_count_q <= op_count_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = accept && (wr_ptr_q == PTR_W'(gi));
  end

  // Entries are cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          mem_q[i] <= wr_entry;
        end
      end
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign in_ready   = in_ready_q;
  assign out_valid  = (occ_q != '0);
  assign out_result = head.result;
  assign out_flag   = head.flag;
  assign out_tag    = head.tag;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: vector table through the ALU at full
// throughput, then hand-written back-pressure, flush and reset sequences.
module tb_alu_exec_stage;
  import alu_exec_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_op;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_flag;
  logic [4:0]  out_tag;
  logic [31:0] op_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] base_cnt;

  always #5 clk = ~clk;

  alu_exec_stage #(
    .DEPTH  (2),
    .DATA_W (32),
    .OP_W   (5),
    .TAG_W  (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flag   (out_flag),
    .out_tag    (out_tag),
    .op_count   (op_count)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] res;
    logic        flg;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 10 && in_ready !== 1'b1; i++) step();
    chk(name, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{ADD_,  32'd1,        32'd2,        5'd7,  32'd3,        1'b0};
    vecs[1]  = '{ADD_,  32'hFFFFFFFF, 32'd1,        5'd1,  32'd0,        1'b0};
    vecs[2]  = '{SUB_,  32'd4,        32'd2,        5'd2,  32'd2,        1'b0};
    vecs[3]  = '{SUB_,  32'd0,        32'd1,        5'd3,  32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{AND_,  32'd3,        32'd1,        5'd4,  32'd1,        1'b0};
    vecs[5]  = '{OR_,   32'd4,        32'd2,        5'd5,  32'd6,        1'b0};
    vecs[6]  = '{XOR_,  32'hF0,       32'hFF,       5'd6,  32'h0F,       1'b0};
    vecs[7]  = '{SLL_,  32'd1,        32'd4,        5'd8,  32'd16,       1'b0};
    vecs[8]  = '{SRL_,  32'h80000000, 32'd31,       5'd9,  32'd1,        1'b0};
    vecs[9]  = '{SRA_,  32'h80000000, 32'd4,        5'd10, 32'hF8000000, 1'b0};
    vecs[10] = '{SLT_,  32'hFFFFFFFF, 32'd1,        5'd11, 32'd1,        1'b0};
    vecs[11] = '{SLTU_, 32'hFFFFFFFF, 32'd1,        5'd12, 32'd0,        1'b0};
    vecs[12] = '{BEQ_,  32'd5,        32'd5,        5'd13, 32'd0,        1'b1};
    vecs[13] = '{BNE_,  32'd3,        32'd3,        5'd14, 32'd0,        1'b0};
    vecs[14] = '{BNE_,  32'd0,        32'd1,        5'd15, 32'd0,        1'b1};
    vecs[15] = '{BLT_,  32'hFFFFFFFF, 32'd0,        5'd16, 32'd0,        1'b1};
    vecs[16] = '{BGEU_, 32'd0,        32'd1,        5'd17, 32'd0,        1'b0};
    vecs[17] = '{5'd31, 32'd9,        32'd9,        5'd31, 32'd0,        1'b0};

    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);

    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_flag", {31'd0, out_flag}, 32'd0);
    chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
    chk("rst_op_count", op_count, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    wait_ready("post_rst_ready");

    // Full-throughput vector table: each result is the head right after its edge.
    out_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      step();
      $display("vec %0d op=%0d a=%h b=%h -> valid=%b res=%h flag=%b tag=%0d cnt=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, out_valid, out_result, out_flag, out_tag, op_count);
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_result", i), out_result, vecs[i].res);
      chk($sformatf("vec%0d_flag", i), {31'd0, out_flag}, {31'd0, vecs[i].flg});
      chk($sformatf("vec%0d_tag", i), {27'd0, out_tag}, {27'd0, vecs[i].tag});
      chk($sformatf("vec%0d_count", i), op_count, 32'(i + 1));
    end
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
    step();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_ready", {31'd0, in_ready}, 32'd1);

    // Back-pressure: two accepts fill the buffer, a third op is held off.
    base_cnt  = op_count;
    out_ready = 1'b0;
    drive(1'b1, AND_, 32'd3, 32'd1, 5'd1);
    step();
    $display("bp push AND -> ready=%b cnt=%0d", in_ready, op_count);
    chk("bp_ready_after1", {31'd0, in_ready}, 32'd1);
    drive(1'b1, OR_, 32'd4, 32'd2, 5'd2);
    step();
    $display("bp push OR -> ready=%b cnt=%0d", in_ready, op_count);
    chk("bp_ready_after2", {31'd0, in_ready}, 32'd0);
    drive(1'b1, SUB_, 32'd4, 32'd2, 5'd3);
    step();
    $display("bp hold SUB -> ready=%b cnt=%0d res=%h", in_ready, op_count, out_result);
    chk("bp_held_count", op_count, base_cnt + 32'd2);
    chk("bp_stable_result", out_result, 32'd1);
    chk("bp_stable_tag", {27'd0, out_tag}, 32'd1);
    out_ready = 1'b1;
    step();
    $display("bp pop -> res=%h tag=%0d", out_result, out_tag);
    chk("bp_second_result", out_result, 32'd6);
    chk("bp_second_tag", {27'd0, out_tag}, 32'd2);
    chk("bp_ready_reopen", {31'd0, in_ready}, 32'd1);
    step();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
    $display("bp pop -> res=%h tag=%0d cnt=%0d", out_result, out_tag, op_count);
    chk("bp_third_result", out_result, 32'd2);
    chk("bp_third_tag", {27'd0, out_tag}, 32'd3);
    chk("bp_third_count", op_count, base_cnt + 32'd3);
    step();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Simultaneous push and pop with one entry resident.
    out_ready = 1'b0;
    drive(1'b1, ADD_, 32'd7, 32'd1, 5'd4);
    step();
    chk("pp_first_result", out_result, 32'd8);
    out_ready = 1'b1;
    drive(1'b1, ADD_, 32'd5, 32'd5, 5'd5);
    step();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
    $display("pp push+pop -> valid=%b res=%h tag=%0d", out_valid, out_result, out_tag);
    chk("pp_valid", {31'd0, out_valid}, 32'd1);
    chk("pp_result", out_result, 32'd10);
    chk("pp_tag", {27'd0, out_tag}, 32'd5);
    step();
    chk("pp_single_left", {31'd0, out_valid}, 32'd0);

    // Flush with a full buffer and an op on the input.
    out_ready = 1'b0;
    drive(1'b1, ADD_, 32'd1, 32'd0, 5'd6);
    step();
    drive(1'b1, ADD_, 32'd2, 32'd0, 5'd7);
    step();
    chk("fl_full_ready", {31'd0, in_ready}, 32'd0);
    base_cnt = op_count;
    flush = 1'b1;
    drive(1'b1, ADD_, 32'd1, 32'd1, 5'd8);
    step();
    flush = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
    $display("flush full -> valid=%b ready=%b cnt=%0d", out_valid, in_ready, op_count);
    chk("fl_full_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_full_ready_after", {31'd0, in_ready}, 32'd1);
    chk("fl_full_count", op_count, base_cnt);

    // Flush with room to accept: the incoming op must still be dropped.
    drive(1'b1, ADD_, 32'd3, 32'd3, 5'd9);
    step();
    chk("fl_part_ready", {31'd0, in_ready}, 32'd1);
    base_cnt = op_count;
    flush = 1'b1;
    drive(1'b1, ADD_, 32'd1, 32'd1, 5'd10);
    step();
    flush = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
    step();
    $display("flush partial -> valid=%b cnt=%0d", out_valid, op_count);
    chk("fl_part_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_part_count", op_count, base_cnt);
    out_ready = 1'b1;
    drive(1'b1, ADD_, 32'd3, 32'd4, 5'd11);
    step();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
    chk("fl_resume_result", out_result, 32'd7);
    chk("fl_resume_tag", {27'd0, out_tag}, 32'd11);
    step();

    // Asynchronous reset asserted between edges with an entry buffered.
    out_ready = 1'b0;
    drive(1'b1, ADD_, 32'd9, 32'd9, 5'd12);
    step();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
    chk("ar_pre_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    $display("async rst -> valid=%b res=%h cnt=%0d", out_valid, out_result, op_count);
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_count", op_count, 32'd0);
    chk("ar_result", out_result, 32'd0);
    #2 rst = 1'b0;
    wait_ready("ar_ready");
    out_ready = 1'b1;
    drive(1'b1, ADD_, 32'd1, 32'd2, 5'd13);
    step();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
    $display("post rst ADD -> res=%h cnt=%0d", out_result, op_count);
    chk("ar_after_result", out_result, 32'd3);
    chk("ar_after_count", op_count, 32'd1);
    step();
    chk("ar_after_empty", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
